// File: rtl/dwise_pkg.sv
// -----------------------------------------------------------------------------
// dwise_pkg
// Shared types and helpers for the depthwise router blocks.
//   fetch_state_t : window fetcher FSM states (also used by the dwise router)
//   cnt_width()   : width of an index counter covering n entries, never below 1
// -----------------------------------------------------------------------------
package dwise_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fetch_state_t;

   // A window of a single address still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/window_fetcher.sv
// -----------------------------------------------------------------------------
// window_fetcher
// Read-side companion of the depthwise address generator. Takes one sliding
// window address set, issues one SRAM read per cycle, assembles the returned
// words into a packed window and hands it to the selected depthwise PE row.
//
// Ports
//   i_clk, i_nrst        clock (rising edge), asynchronous active-low reset
//   i_reg_clear          synchronous clear, beats everything except reset
//   i_valid / o_ready    address set handshake (o_ready is combinational)
//   i_addr               window addresses, element 0 is fetched first
//   i_o_x, i_o_y         output coordinates, latched on accept
//   i_row_id             destination row id, latched on accept
//   o_sram_re            SRAM read enable
//   o_sram_addr          SRAM read address, zero while o_sram_re is low
//   i_sram_rdata         SRAM word, valid one cycle after o_sram_re
//   o_valid / i_ready    completed window handshake
//   o_data               packed window, o_data[k] = mem[i_addr[k]]
//   o_o_x, o_o_y         latched coordinates
//   o_row_id             latched row id
// -----------------------------------------------------------------------------
module window_fetcher
   import dwise_pkg::*;
#(
   parameter int ROWS        = 4,
   parameter int ADDR_WIDTH  = 6,
   parameter int ADDR_LENGTH = 9,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                                      i_clk,
   input  logic                                      i_nrst,
   input  logic                                      i_reg_clear,
   input  logic                                      i_valid,
   output logic                                      o_ready,
   input  logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]    i_addr,
   input  logic [ADDR_WIDTH-1:0]                     i_o_x,
   input  logic [ADDR_WIDTH-1:0]                     i_o_y,
   input  logic [ROWS-1:0]                           i_row_id,
   output logic                                      o_sram_re,
   output logic [ADDR_WIDTH-1:0]                     o_sram_addr,
   input  logic [DATA_WIDTH-1:0]                     i_sram_rdata,
   output logic                                      o_valid,
   input  logic                                      i_ready,
   output logic [0:ADDR_LENGTH-1][DATA_WIDTH-1:0]    o_data,
   output logic [ADDR_WIDTH-1:0]                     o_o_x,
   output logic [ADDR_WIDTH-1:0]                     o_o_y,
   output logic [ROWS-1:0]                           o_row_id
);

   localparam int               CNT_W    = cnt_width(ADDR_LENGTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_LENGTH - 1);

   fetch_state_t                              state_q;
   fetch_state_t                              state_d;
   logic [CNT_W-1:0]                          cnt_q;
   logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]    addr_q;
   logic                                      rd_pending_q;
   logic [CNT_W-1:0]                          rd_idx_q;
   logic                                      accept;

   // --------------------------------------------------------------------------
   // Next state and outputs
   // --------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      o_ready     = 1'b0;
      o_valid     = 1'b0;
      o_sram_re   = 1'b0;
      o_sram_addr = '0;
      accept      = 1'b0;

      // A finished window can be replaced in the same cycle it is consumed,
      // which is what gives back-to-back windows no idle bubble.
      o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
      accept  = i_valid && o_ready;
      o_valid = (state_q == DONE);

      if (state_q == FETCH) begin
         o_sram_re   = 1'b1;
         o_sram_addr = addr_q[cnt_q];
      end

      case (state_q)
         IDLE: begin
            if (accept) state_d = FETCH;
         end
         FETCH: begin
            if (cnt_q == CNT_LAST) state_d = DRAIN;
         end
         DRAIN: begin
            // Last read is still in flight; its word lands this cycle.
            state_d = DONE;
         end
         DONE: begin
            if (accept)       state_d = FETCH;
            else if (i_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // State, counter, latched set and capture registers
   // --------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         rd_pending_q <= 1'b0;
         rd_idx_q     <= '0;
         o_data       <= '0;
         o_o_x        <= '0;
         o_o_y        <= '0;
         o_row_id     <= '0;
      end else if (i_reg_clear) begin
         // Dropping rd_pending discards the read issued this cycle, so the
         // word returning on the next cycle never lands in o_data.
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         rd_pending_q <= 1'b0;
         rd_idx_q     <= '0;
         o_data       <= '0;
         o_o_x        <= '0;
         o_o_y        <= '0;
         o_row_id     <= '0;
      end else begin
         state_q <= state_d;

         if (accept) begin
            addr_q   <= i_addr;
            o_o_x    <= i_o_x;
            o_o_y    <= i_o_y;
            o_row_id <= i_row_id;
            cnt_q    <= '0;
         end else if (state_q == FETCH) begin
            cnt_q <= cnt_q + 1'b1;
         end

         // SRAM has one cycle of read latency: remember which slot the
         // current read belongs to and fill it when the word comes back.
         rd_pending_q <= o_sram_re;
         rd_idx_q     <= cnt_q;
         if (rd_pending_q) begin
            o_data[rd_idx_q] <= i_sram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_window_fetcher.sv
// -----------------------------------------------------------------------------
// tb_window_fetcher
// Directed bench for window_fetcher with an SRAM model (mem[a] = 3a) and a
// window-level reference that tracks how many edges have passed since each
// accepted address set.
// -----------------------------------------------------------------------------
module tb_window_fetcher;

   localparam int ROWS = 4;
   localparam int AW   = 6;
   localparam int LEN  = 9;
   localparam int DW   = 8;

   logic                     i_clk;
   logic                     i_nrst;
   logic                     i_reg_clear;
   logic                     i_valid;
   logic                     o_ready;
   logic [0:LEN-1][AW-1:0]   i_addr;
   logic [AW-1:0]            i_o_x;
   logic [AW-1:0]            i_o_y;
   logic [ROWS-1:0]          i_row_id;
   logic                     o_sram_re;
   logic [AW-1:0]            o_sram_addr;
   logic [DW-1:0]            i_sram_rdata;
   logic                     o_valid;
   logic                     i_ready;
   logic [0:LEN-1][DW-1:0]   o_data;
   logic [AW-1:0]            o_o_x;
   logic [AW-1:0]            o_o_y;
   logic [ROWS-1:0]          o_row_id;

   window_fetcher #(
      .ROWS(ROWS), .ADDR_WIDTH(AW), .ADDR_LENGTH(LEN), .DATA_WIDTH(DW)
   ) dut (
      .i_clk(i_clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear),
      .i_valid(i_valid), .o_ready(o_ready), .i_addr(i_addr),
      .i_o_x(i_o_x), .i_o_y(i_o_y), .i_row_id(i_row_id),
      .o_sram_re(o_sram_re), .o_sram_addr(o_sram_addr),
      .i_sram_rdata(i_sram_rdata), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_o_x(o_o_x), .o_o_y(o_o_y), .o_row_id(o_row_id)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit rec      = 0;
   logic [AW-1:0] addr_log[$];

   always @(posedge i_clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      return DW'(3 * int'(a));
   endfunction

   // SRAM: one cycle read latency, garbage when not read
   always @(posedge i_clk) begin
      if (o_sram_re) i_sram_rdata <= memf(o_sram_addr);
      else           i_sram_rdata <= DW'($urandom);
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // ---------------- reference model ----------------
   // ph = -1 idle; 0..LEN-1 fetching element ph; LEN draining; LEN+1 done
   int                      ph;
   logic [0:LEN-1][AW-1:0]  m_addr;
   logic [AW-1:0]           m_x, m_y;
   logic [ROWS-1:0]         m_row;

   always @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         ph <= -1;
      end else if (i_reg_clear) begin
         ph <= -1;
      end else if (i_valid && ((ph < 0) || (ph == LEN + 1 && i_ready))) begin
         ph     <= 0;
         m_addr <= i_addr;
         m_x    <= i_o_x;
         m_y    <= i_o_y;
         m_row  <= i_row_id;
      end else if (ph == LEN + 1) begin
         if (i_ready) ph <= -1;
      end else if (ph >= 0) begin
         ph <= ph + 1;
      end
   end

   always @(negedge i_clk) begin
      if (i_nrst) begin
         logic                    e_re, e_rdy, e_vld;
         logic [AW-1:0]           e_addr;
         logic [0:LEN-1][DW-1:0]  e_data;
         e_rdy  = (ph < 0) || (ph == LEN + 1 && i_ready);
         e_re   = (ph >= 0) && (ph < LEN);
         e_addr = e_re ? m_addr[ph] : '0;
         e_vld  = (ph == LEN + 1);
         chk("ready", 128'(o_ready), 128'(e_rdy));
         chk("valid", 128'(o_valid), 128'(e_vld));
         chk("sram_re", 128'(o_sram_re), 128'(e_re));
         chk("sram_addr", 128'(o_sram_addr), 128'(e_addr));
         if (e_vld) begin
            for (int k = 0; k < LEN; k++) e_data[k] = memf(m_addr[k]);
            chk("data", 128'(o_data), 128'(e_data));
            chk("o_x", 128'(o_o_x), 128'(m_x));
            chk("o_y", 128'(o_o_y), 128'(m_y));
            chk("row", 128'(o_row_id), 128'(m_row));
         end
         if (rec && o_sram_re) addr_log.push_back(o_sram_addr);
      end
   end

   // ---------------- stimulus helpers ----------------
   // Call at posedge+#1; returns with acc = cycle number of the accept edge.
   task automatic send(input logic [0:LEN-1][AW-1:0] a, input logic [AW-1:0] x,
                       input logic [AW-1:0] y, input logic [ROWS-1:0] r, output int acc);
      i_addr = a; i_o_x = x; i_o_y = y; i_row_id = r; i_valid = 1'b1;
      acc = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge i_clk);
         if (o_ready) begin
            @(posedge i_clk); #1;
            acc = cyc;
            break;
         end
      end
      i_valid = 1'b0;
      if (acc < 0) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_valid(output int t);
      t = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge i_clk);
         if (o_valid) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) chk("valid_timeout", 0, 1);
   endtask

   logic [0:LEN-1][AW-1:0] win_a, win_b, win_c, win_d, win_e;
   logic [0:LEN-1][DW-1:0] dat_a, dat_c, dat_d;
   logic [0:LEN-1][AW-1:0] seq;

   initial begin
      int acc, t, t1, t2;
      win_a = {6'd0, 6'd1, 6'd2, 6'd8, 6'd9, 6'd10, 6'd16, 6'd17, 6'd18};
      dat_a = {8'd0, 8'd3, 8'd6, 8'd24, 8'd27, 8'd30, 8'd48, 8'd51, 8'd54};
      win_b = {6'd5, 6'd6, 6'd7, 6'd13, 6'd14, 6'd15, 6'd21, 6'd22, 6'd23};
      win_c = {6'd40, 6'd41, 6'd42, 6'd48, 6'd49, 6'd50, 6'd56, 6'd57, 6'd58};
      dat_c = {8'd120, 8'd123, 8'd126, 8'd144, 8'd147, 8'd150, 8'd168, 8'd171, 8'd174};
      win_d = {6'd3, 6'd4, 6'd5, 6'd11, 6'd12, 6'd13, 6'd19, 6'd20, 6'd21};
      dat_d = {8'd9, 8'd12, 8'd15, 8'd33, 8'd36, 8'd39, 8'd57, 8'd60, 8'd63};
      win_e = {6'd63, 6'd62, 6'd61, 6'd55, 6'd54, 6'd53, 6'd47, 6'd46, 6'd45};

      i_nrst = 1'b0; i_reg_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
      i_addr = '0; i_o_x = '0; i_o_y = '0; i_row_id = '0;
      repeat (3) @(posedge i_clk);
      #1 i_nrst = 1'b1;

      // reset state
      chk("rst_ready", 128'(o_ready), 1);
      chk("rst_valid", 128'(o_valid), 0);
      chk("rst_re", 128'(o_sram_re), 0);
      chk("rst_data", 128'(o_data), 0);

      // single window
      @(posedge i_clk); #1;
      rec = 1;
      send(win_a, 6'd2, 6'd5, 4'b0010, acc);
      wait_valid(t);
      rec = 0;
      chk("latency", 128'(t - acc), 10);
      chk("addr_count", 128'(addr_log.size()), 9);
      seq = '0;
      for (int k = 0; k < LEN && k < addr_log.size(); k++) seq[k] = addr_log[k];
      chk("addr_seq", 128'(seq), 128'(win_a));
      chk("single_data", 128'(o_data), 128'(dat_a));
      chk("single_x", 128'(o_o_x), 2);
      chk("single_y", 128'(o_o_y), 5);
      chk("single_row", 128'(o_row_id), 2);

      // backpressure: hold i_ready low 5 cycles, pulse i_valid once
      for (int n = 0; n < 5; n++) begin
         @(posedge i_clk); #1;
         i_addr = win_b;
         i_valid = (n == 2);
         @(negedge i_clk);
         chk("bp_valid", 128'(o_valid), 1);
         chk("bp_ready", 128'(o_ready), 0);
         chk("bp_re", 128'(o_sram_re), 0);
         chk("bp_data", 128'(o_data), 128'(dat_a));
      end
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_ready = 1'b1;
      @(posedge i_clk); #1;
      chk("bp_release", 128'(o_valid), 0);

      // back-to-back windows
      send(win_b, 6'd1, 6'd1, 4'b0001, acc);
      i_addr = win_c; i_o_x = 6'd7; i_o_y = 6'd9; i_row_id = 4'b1000; i_valid = 1'b1;
      t1 = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge i_clk);
         if (o_ready) begin
            t1 = cyc;
            break;
         end
      end
      chk("b2b_first_valid", 128'(o_valid), 1);
      chk("b2b_first_lat", 128'(t1 - acc), 10);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      wait_valid(t2);
      chk("b2b_period", 128'(t2 - t1), 11);
      chk("b2b_data", 128'(o_data), 128'(dat_c));
      chk("b2b_row", 128'(o_row_id), 128'(4'b1000));

      // clear in the middle of a fetch
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      send(win_d, 6'd3, 6'd4, 4'b0100, acc);
      repeat (4) @(posedge i_clk);
      #1 i_reg_clear = 1'b1;
      @(negedge i_clk);
      chk("clr_addr4", 128'(o_sram_addr), 12);
      @(posedge i_clk); #1;
      i_reg_clear = 1'b0;
      chk("clr_data", 128'(o_data), 0);
      chk("clr_valid", 128'(o_valid), 0);
      chk("clr_ready", 128'(o_ready), 1);
      chk("clr_x", 128'(o_o_x), 0);
      @(posedge i_clk); #1;
      chk("clr_stale", 128'(o_data), 0);
      i_ready = 1'b1;
      send(win_d, 6'd3, 6'd4, 4'b0100, acc);
      wait_valid(t);
      chk("clr_next_data", 128'(o_data), 128'(dat_d));

      // clear coincident with valid in IDLE
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_addr = win_b; i_valid = 1'b1; i_reg_clear = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_reg_clear = 1'b0;
      @(negedge i_clk);
      chk("coll_re", 128'(o_sram_re), 0);
      chk("coll_ready", 128'(o_ready), 1);

      // async reset in the middle of a fetch
      @(posedge i_clk); #1;
      i_ready = 1'b0;
      send(win_e, 6'd33, 6'd44, 4'b1010, acc);
      repeat (3) @(posedge i_clk);
      #1 i_nrst = 1'b0;
      #1;
      chk("arst_valid", 128'(o_valid), 0);
      chk("arst_re", 128'(o_sram_re), 0);
      chk("arst_addr", 128'(o_sram_addr), 0);
      chk("arst_data", 128'(o_data), 0);
      chk("arst_x", 128'(o_o_x), 0);
      chk("arst_y", 128'(o_o_y), 0);
      chk("arst_row", 128'(o_row_id), 0);
      @(posedge i_clk); #1;
      i_nrst = 1'b1;
      @(negedge i_clk);
      chk("arst_ready", 128'(o_ready), 1);

      // recovery window
      @(posedge i_clk); #1;
      i_ready = 1'b1;
      send(win_a, 6'd2, 6'd5, 4'b0010, acc);
      wait_valid(t);
      chk("final_data", 128'(o_data), 128'(dat_a));
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/window_fetcher.md
# window_fetcher

Read-side companion of the depthwise address generator. Accepts one 3×3 sliding-window address set (ADDR_LENGTH addresses plus output coordinates and row id), issues one SRAM read per cycle, collects the returned elements into a packed window, and presents the completed window with a valid/ready handshake to the depthwise PE row selected by the row id. It sits between the dwise address generator and the activation SRAM read port in the dwise router.

## Interface

**Parameters**
- ROWS, 4, width of row-id field
- ADDR_WIDTH, 6, SRAM address and coordinate width
- ADDR_LENGTH, 9, addresses per window (KERNEL_SIZE²)
- DATA_WIDTH, 8, SRAM word / activation width

**Ports**
- i_clk  in  1  clock, rising edge
- i_nrst  in  1  asynchronous active-low reset
- i_reg_clear  in  1  synchronous clear, highest priority after reset
- i_valid  in  1  address set valid
- o_ready  out  1  block can accept an address set this cycle
- i_addr  in  [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]  window addresses, index 0 fetched first
- i_o_x, i_o_y  in  ADDR_WIDTH each  output coordinates, passed through
- i_row_id  in  ROWS  destination row id, passed through
- o_sram_re  out  1  SRAM read enable
- o_sram_addr  out  ADDR_WIDTH  SRAM read address
- i_sram_rdata  in  DATA_WIDTH  SRAM data, valid exactly one cycle after o_sram_re
- o_valid  out  1  window complete
- i_ready  in  1  downstream accepts window
- o_data  out  [0:ADDR_LENGTH-1][DATA_WIDTH-1:0]  window, o_data[k] = mem[i_addr[k]]
- o_o_x, o_o_y  out  ADDR_WIDTH each  latched coordinates
- o_row_id  out  ROWS  latched row id

## Operation

- States: IDLE, FETCH, DRAIN, DONE.
- Accept = i_valid && o_ready. o_ready = (IDLE) || (DONE && i_ready). i_valid while o_ready low is ignored (no latch); the upstream does not present a set unless o_ready is high.
- On accept: latch i_addr, i_o_x, i_o_y, i_row_id; clear index counter; go to FETCH; o_valid drops.
- FETCH: o_sram_re=1, o_sram_addr = addr_q[cnt]; cnt increments each cycle; after cnt = ADDR_LENGTH-1 go to DRAIN.
- Capture: rd_pending/rd_idx registers delay (re, cnt) by one cycle; when rd_pending, o_data[rd_idx] <= i_sram_rdata.
- DRAIN: o_sram_re=0, captures the last element, then DONE.
- DONE: o_valid=1; outputs stable. i_ready&&!i_valid → IDLE; i_ready&&i_valid → accept (FETCH).
- o_sram_addr is '0 whenever o_sram_re=0.
- cnt width max(1,$clog2(ADDR_LENGTH)); ADDR_LENGTH=1 gives a 1-cycle FETCH.

## Timing

- Reset (async) and i_reg_clear (sync): state IDLE, o_ready=1, o_valid=0, o_sram_re=0, o_sram_addr=0, o_data=0, o_o_x=o_o_y=0, o_row_id=0, rd_pending=0. Mid-operation the in-flight read is discarded; an SRAM word returning the next cycle is not captured.
- Accept at edge E0; o_sram_re high between E0 and E_ADDR_LENGTH; DRAIN one cycle; o_valid high after edge E(ADDR_LENGTH+1) (E10 by default).
- Back-to-back throughput: one window per ADDR_LENGTH+2 cycles (11 default) when i_ready is held high.
- i_reg_clear coincident with i_valid: clear wins, set not accepted.
- o_data/o_o_x/o_o_y/o_row_id hold from DONE until the next accept (o_data elements are overwritten progressively during the next FETCH; valid only while o_valid=1).

## Structure

- dwise_pkg: typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t; shared with the dwise router.
- No sub-module; FSM, counter, capture registers inline in one always_ff plus one always_comb.

## Test plan

- Reset/idle: assert i_nrst=0 mid-FETCH → all outputs at reset values on the same cycle, o_ready=1 after release.
- Single window: SRAM model mem[a]=3a, i_addr={0,1,2,8,9,10,16,17,18}, x=2,y=5,row=4'b0010 → o_sram_addr sequence 0,1,2,8,9,10,16,17,18 on cycles 1–9, o_valid after 10 edges, o_data={0,3,6,24,27,30,48,51,54}, o_o_x=2, o_o_y=5, o_row_id=2.
- Backpressure: i_ready low 5 cycles in DONE → o_valid and o_data stable, o_ready=0, a pulsed i_valid is ignored and no o_sram_re issued.
- Back-to-back: i_ready=1, new i_valid in DONE → accepted same edge, second window o_valid exactly 11 cycles after the first.
- Clear mid-fetch: i_reg_clear at cnt=4 → IDLE next cycle, o_data=0, following SRAM word not captured, next window correct.
- Clear vs valid collision: i_reg_clear=1 and i_valid=1 in IDLE → no accept, o_sram_re stays 0.
